ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared open-collector PS2_CLK/PS2_DATA lines.

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_host_tx.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, timing helpers and command codes
// Contents: FSM state encoding for the host transmitter, default timing
// parameters with INHIBIT_CYC/TIMEOUT_CYC derived from them, helpers that
// derive cycle counts from arbitrary parameter values, common keyboard
// command bytes and the odd-parity function used for the frame parity bit.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_RELEASE,
    ST_DONE
  } state_t;

  localparam int DEF_CLK_HZ     = 100_000_000;
  localparam int DEF_INHIBIT_US = 100;
  localparam int DEF_TIMEOUT_MS = 15;
  localparam int DEF_FILT       = 8;

  // Cycle counts for the default build; instances with other parameter
  // values derive their own through the helpers below.
  localparam int INHIBIT_CYC = DEF_CLK_HZ / 1_000_000 * DEF_INHIBIT_US;
  localparam int TIMEOUT_CYC = DEF_CLK_HZ / 1000 * DEF_TIMEOUT_MS;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  function automatic int inhibit_cycles(input int clk_hz, input int inhibit_us);
    return clk_hz / 1_000_000 * inhibit_us;
  endfunction

  function automatic int timeout_cycles(input int clk_hz, input int timeout_ms);
    return clk_hz / 1000 * timeout_ms;
  endfunction

  // Parity bit that makes the 9-bit {parity, data} field contain an odd
  // number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchroniser and stability filter
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   raw   in   asynchronous open-collector line level
//   level out  filtered line level (idle high)
//   fall  out  one-cycle pulse when the filtered level goes 1 -> 0
module ps2_line_filter #(
  parameter int FILT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILT + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // The synchronised level must disagree with the accepted level for FILT
  // consecutive cycles before it is taken; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        level <= sync[1];
        fall  <= level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   tx_data, tx_valid     command byte and request (accepted with tx_ready)
//   tx_ready              high only while idle
//   ps2_clk_i, ps2_data_i raw line levels
//   ps2_clk_oe            1 = pull PS2_CLK low
//   ps2_data_oe           1 = pull PS2_DATA low
//   busy                  high from accept until done
//   done                  one-cycle end-of-transfer pulse
//   ack_ok, err_timeout   result flags, valid with done, held until next accept
// Macro PS2_TX_RETRY_EN: when defined, a NACK or timeout restarts the frame
// from the inhibit phase up to two times before done is reported.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int INHIBIT_US = DEF_INHIBIT_US,
  parameter int TIMEOUT_MS = DEF_TIMEOUT_MS,
  parameter int FILT       = DEF_FILT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int          INH_CYC  = inhibit_cycles(CLK_HZ, INHIBIT_US);
  localparam int          TMO_CYC  = timeout_cycles(CLK_HZ, TIMEOUT_MS);
  localparam logic [31:0] INH_LAST = 32'(INH_CYC - 1);
  localparam logic [31:0] TMO_LAST = 32'(TMO_CYC - 1);

  state_t      state;
  logic [8:0]  frame;     // {parity, data}, shifted out LSB first
  logic [3:0]  bit_cnt;   // falls seen so far in SEND
  logic [31:0] cnt;       // inhibit length in INHIBIT, timeout otherwise

  logic clk_lvl, clk_fall;
  logic data_lvl, unused_data_fall;
  logic tmo_hit, tmo_event, nack_event, fail_event, can_retry;

  ps2_line_filter #(.FILT(FILT)) u_clk_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2_clk_i),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.FILT(FILT)) u_data_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2_data_i),
    .level (data_lvl),
    .fall  (unused_data_fall)
  );

`ifdef PS2_TX_RETRY_EN
  localparam logic [1:0] MAX_RETRY = 2'd2;
  logic [1:0] retry_cnt;
  assign can_retry = (retry_cnt != MAX_RETRY);
`else
  assign can_retry = 1'b0;
`endif

  assign tmo_hit = (cnt == TMO_LAST);

  // A device edge arriving in the same cycle as the timeout wins.
  always_comb begin
    tmo_event = 1'b0;
    case (state)
      ST_SEND, ST_ACK: tmo_event = tmo_hit && !clk_fall;
      ST_RELEASE:      tmo_event = tmo_hit && !(clk_lvl && data_lvl);
      default:         tmo_event = 1'b0;
    endcase
  end

  assign nack_event = (state == ST_RELEASE) && clk_lvl && data_lvl && !ack_ok;
  assign fail_event = tmo_event || nack_event;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err_timeout <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            frame       <= {odd_parity(tx_data), tx_data};
            bit_cnt     <= '0;
            cnt         <= '0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b1;
            tx_ready    <= 1'b0;
            ack_ok      <= 1'b0;
            err_timeout <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_cnt   <= '0;
`endif
            state       <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (cnt == INH_LAST) begin
            // Clock released and start bit driven in the same cycle.
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            state       <= ST_REQ;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_REQ: begin
          cnt   <= '0;
          state <= ST_SEND;
        end

        ST_SEND: begin
          if (clk_fall) begin
            cnt <= '0;
            if (bit_cnt == 4'd9) begin
              ps2_data_oe <= 1'b0;    // stop bit: line released
              state       <= ST_ACK;
            end else begin
              ps2_data_oe <= ~frame[bit_cnt];
              bit_cnt     <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_ACK: begin
          if (clk_fall) begin
            ack_ok <= ~data_lvl;
            cnt    <= '0;
            state  <= ST_RELEASE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_RELEASE: begin
          if (clk_lvl && data_lvl) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_DONE: begin
          busy     <= 1'b0;
          tx_ready <= 1'b1;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase

      // Failure handling overrides whatever the state arm scheduled above.
      if (fail_event) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        ack_ok      <= 1'b0;
        cnt         <= '0;
        bit_cnt     <= '0;
        if (can_retry) begin
          ps2_clk_oe  <= 1'b1;
          err_timeout <= 1'b0;
          done        <= 1'b0;
          state       <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_cnt   <= retry_cnt + 2'd1;
`endif
        end else begin
          err_timeout <= tmo_event;
          done        <= 1'b1;
          state       <= ST_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int CLK_HZ_TB = 1_000_000;
  localparam int INH       = CLK_HZ_TB / 1_000_000 * 100;   // 100 cycles
  localparam int TMO       = CLK_HZ_TB / 1000 * 1;          // 1000 cycles
  localparam int H         = 40;                            // device half period (12.5 kHz)
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err_timeout;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.CLK_HZ(CLK_HZ_TB), .INHIBIT_US(100), .TIMEOUT_MS(1), .FILT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (ps2_clk_line),
    .ps2_data_i  (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .err_timeout (err_timeout)
  );

  typedef struct {
    logic ack;
    logic tmo;
  } exp_done_t;

  exp_done_t   exp_done_q[$];
  logic [10:0] exp_frame_q[$];
  logic [10:0] obs_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, last_req_cyc = 0, req_count = 0, fall_count = 0;
  int dev_mode = M_ACK;
  bit dev_abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference frame as the device should see it: start 0, data LSB first,
  // parity making the count of ones odd, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  // Device: once the host releases clock with data low, clock 11 pulses,
  // sample each bit on the rising edge, answer ACK (or not) on pulse 11.
  task automatic run_frame();
    logic [10:0] obs;
    obs = '0;
    repeat (H) @(negedge clk);
    obs[0] = ps2_data_line;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && dev_mode == M_ACK) begin
        dev_data = 1'b0;
        repeat (2) @(negedge clk);
      end
      dev_clk    = 1'b0;
      fall_count = i;
      repeat (H) @(negedge clk);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      if (dev_abort) begin
        fall_count = 0;
        return;
      end
      if (i <= 10) obs[i] = ps2_data_line;
      repeat (H) @(negedge clk);
      if (dev_abort) begin
        fall_count = 0;
        return;
      end
    end
    fall_count = 0;
    obs_q.push_back(obs);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !dev_abort && dev_mode != M_SILENT && ps2_clk_line && !ps2_data_line)
        run_frame();
    end
  end

  // Frame monitor
  initial begin
    logic [10:0] o, e;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_frame_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=%03h required=none", o);
        end else begin
          e = exp_frame_q.pop_front();
          chk("frame_bits", 32'(o), 32'(e));
        end
      end
    end
  end

  // Done monitor
  initial begin
    exp_done_t e;
    int lat;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = exp_done_q.pop_front();
          chk("done_ack_ok", 32'(ack_ok), 32'(e.ack));
          chk("done_err_timeout", 32'(err_timeout), 32'(e.tmo));
          if (e.tmo) begin
            lat = cyc - last_req_cyc;
            chk("timeout_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            chk("timeout_latency_ok", 32'(lat >= TMO && lat <= TMO + 2), 32'd1);
          end
        end
      end
    end
  end

  // Line monitor: inhibit length and clock/data handover
  initial begin
    logic prev_data_oe, prev_clk_oe;
    int   clk_run;
    prev_data_oe = 1'b0;
    prev_clk_oe  = 1'b0;
    clk_run      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        clk_run = 0;
      end else begin
        if (ps2_data_oe && !prev_data_oe && !ps2_clk_oe && prev_clk_oe) begin
          last_req_cyc = cyc;
          req_count++;
        end else if (ps2_data_oe && !prev_data_oe && prev_clk_oe) begin
          chk("handover_clk_released", 32'(ps2_clk_oe), 32'd0);
        end
        if (ps2_clk_oe) clk_run++;
        else if (prev_clk_oe) begin
          chk("inhibit_len", 32'(clk_run), 32'(INH));
          clk_run = 0;
        end
      end
      prev_data_oe = rst ? 1'b0 : ps2_data_oe;
      prev_clk_oe  = rst ? 1'b0 : ps2_clk_oe;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog actual=%0d cycles required=finish", cyc);
    $fatal(1, "bench did not finish");
  end

  task automatic issue(input logic [7:0] d, input int mode, input bit expect_resp);
    exp_done_t e;
    int n;
    if (expect_resp) begin
      n = (mode == M_ACK) ? 1 : ATTEMPTS;
      if (mode != M_SILENT)
        for (int k = 0; k < n; k++) exp_frame_q.push_back(ref_frame(d));
      e.ack = (mode == M_ACK);
      e.tmo = (mode == M_SILENT);
      exp_done_q.push_back(e);
    end
    dev_mode = mode;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(tx_ready && !busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_wait actual=busy required=idle", tag);
    end
  endtask

  task automatic wait_fall(input int k);
    int n;
    n = 0;
    while (fall_count != k && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL wait_fall_%0d actual=%0d required=%0d", k, fall_count, k);
    end
  endtask

  initial begin
    int base;
    logic [7:0] d;
    repeat (5) @(negedge clk);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", {30'd0, ack_ok, err_timeout}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    issue(CMD_SET_LED, M_ACK, 1'b1);  wait_idle("set_led");
    issue(CMD_ENABLE, M_ACK, 1'b1);   wait_idle("enable");
    issue(8'h00, M_ACK, 1'b1);        wait_idle("zero");
    issue(CMD_RESET, M_NACK, 1'b1);   wait_idle("nack");
    base = req_count;
    issue(CMD_ENABLE, M_SILENT, 1'b1); wait_idle("timeout");
    chk("timeout_attempts", 32'(req_count - base), 32'(ATTEMPTS));

    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom_range(0, 255));
      issue(d, ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK, 1'b1);
      wait_idle("random");
    end

    // Request while busy must be ignored
    base = req_count;
    issue(CMD_SET_LED, M_ACK, 1'b1);
    wait_fall(3);
    @(negedge clk);
    tx_data  = CMD_RESET;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle("ignore");
    repeat (300) @(negedge clk);
    chk("ignored_single_request", 32'(req_count - base), 32'd1);

    // Reset in the middle of a frame
    issue(CMD_RESET, M_ACK, 1'b0);
    wait_fall(5);
    dev_abort = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    dev_abort = 1'b0;
    chk("midrst_flags", {30'd0, ack_ok, err_timeout}, 32'd0);

    issue(CMD_ENABLE, M_ACK, 1'b1);   wait_idle("after_rst");
    repeat (200) @(negedge clk);
    chk("frames_outstanding", 32'(exp_frame_q.size()), 32'd0);
    chk("dones_outstanding", 32'(exp_done_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
